// File: rtl/game_renderer_multi.sv
// game_renderer_multi: maps pixel coordinates to RRRGGGBB colour for N balls, paddle, housing and block grid.
// Two-stage pipeline; optional SCANLINE_DIM_EN halves every channel on odd lines.
module game_renderer_multi #(
  parameter int unsigned BLOCK_COLS         = 9,
  parameter int unsigned BLOCK_ROWS         = 8,
  parameter int unsigned BALL_COUNT         = 2,
  parameter int unsigned BALL_SIZE_PX       = 8,
  parameter int unsigned PADDLE_LEN_PX      = 64,
  parameter int unsigned CEILING_Y_TILE     = 2,
  parameter int unsigned LEFT_WALL_X_TILE   = 3,
  parameter int unsigned RIGHT_WALL_X_TILE  = 96,
  parameter int unsigned PADDLE_Y_TILE      = 72,
  parameter int unsigned BLOCK_START_X_TILE = 4,
  parameter int unsigned BLOCK_START_Y_TILE = 6,
  parameter int unsigned FRAME_LINE         = 600,
  parameter int unsigned FLASH_FRAMES       = 8,
  parameter logic [7:0]  FLASH_COLOR        = 8'hFC
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic [9:0]                         X_PIXEL,
  input  logic [9:0]                         Y_PIXEL,
  input  logic [9:0]                         PADDLE_X_PIXEL,
  input  logic [10*BALL_COUNT-1:0]           BALL_X_PIXEL,
  input  logic [10*BALL_COUNT-1:0]           BALL_Y_PIXEL,
  input  logic [BLOCK_ROWS*BLOCK_COLS-1:0]   BLOCK_STATE,
  output logic [7:0]                         COLOR,
  output logic                               FRAME_DONE
);

  localparam int unsigned SUM_W      = 11;
  localparam int unsigned TILE_W     = 7;
  localparam int unsigned BIDX_W     = 14;
  localparam int unsigned NUM_BLOCKS = BLOCK_ROWS * BLOCK_COLS;
  localparam int unsigned IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  // Frame-stable shadow of the game state
  logic [9:0]              paddleXSh;
  logic [10*BALL_COUNT-1:0] ballXSh;
  logic [10*BALL_COUNT-1:0] ballYSh;
  logic [NUM_BLOCKS-1:0]   blockSh;
  logic                    shadowValid;
  logic [IDX_W-1:0]        flashIdx;
  logic [7:0]              flashCnt;

  // Stage 1 registers
  logic                    housingQ;
  logic                    paddleQ;
  logic                    ballQ;
  logic                    inGridQ;
  logic [TILE_W-1:0]       blockRowQ;
  logic [TILE_W-1:0]       blockColQ;
`ifdef SCANLINE_DIM_EN
  logic                    oddLineQ;
`endif

  logic                    frameStrobe_c;
  logic [NUM_BLOCKS-1:0]   cleared_c;
  logic [IDX_W-1:0]        lowIdx_c;
  logic [TILE_W-1:0]       xTile_c;
  logic [TILE_W-1:0]       yTile_c;
  logic [TILE_W-1:0]       blockCol_c;
  logic [TILE_W-1:0]       blockRow_c;
  logic                    housing_c;
  logic                    paddle_c;
  logic                    ball_c;
  logic                    inGrid_c;
  logic [BIDX_W-1:0]       blkIdx_c;
  logic                    present_c;
  logic                    flashHit_c;
  logic [2:0]              rowMod_c;
  logic [7:0]              palette_c;
  logic [7:0]              color_c;
  logic [7:0]              colorNext_c;

  assign frameStrobe_c = (X_PIXEL == 10'd0) && (Y_PIXEL == 10'(FRAME_LINE));
  assign cleared_c     = blockSh & ~BLOCK_STATE;

  // Lowest newly cleared block index
  always_comb begin
    lowIdx_c = '0;
    for (int i = int'(NUM_BLOCKS) - 1; i >= 0; i--) begin
      if (cleared_c[i]) lowIdx_c = IDX_W'(i);
    end
  end

  // Stage 1 hit tests, all against shadow state
  always_comb begin
    xTile_c    = X_PIXEL[9:3];
    yTile_c    = Y_PIXEL[9:3];
    housing_c  = ((yTile_c == TILE_W'(CEILING_Y_TILE)) &&
                  (xTile_c >= TILE_W'(LEFT_WALL_X_TILE)) &&
                  (xTile_c <= TILE_W'(RIGHT_WALL_X_TILE))) ||
                 (((xTile_c == TILE_W'(LEFT_WALL_X_TILE)) ||
                   (xTile_c == TILE_W'(RIGHT_WALL_X_TILE))) &&
                  (yTile_c >= TILE_W'(CEILING_Y_TILE)));
    paddle_c   = shadowValid && (yTile_c == TILE_W'(PADDLE_Y_TILE)) &&
                 (SUM_W'(X_PIXEL) >= SUM_W'(paddleXSh)) &&
                 (SUM_W'(X_PIXEL) < SUM_W'(paddleXSh) + SUM_W'(PADDLE_LEN_PX));
    ball_c     = 1'b0;
    for (int i = 0; i < int'(BALL_COUNT); i++) begin
      if ((SUM_W'(X_PIXEL) >= SUM_W'(ballXSh[10*i +: 10])) &&
          (SUM_W'(X_PIXEL) <  SUM_W'(ballXSh[10*i +: 10]) + SUM_W'(BALL_SIZE_PX)) &&
          (SUM_W'(Y_PIXEL) >= SUM_W'(ballYSh[10*i +: 10])) &&
          (SUM_W'(Y_PIXEL) <  SUM_W'(ballYSh[10*i +: 10]) + SUM_W'(BALL_SIZE_PX)))
        ball_c = 1'b1;
    end
    ball_c     = ball_c && shadowValid;
    // Left of / above the grid underflows to large values and falls outside
    blockCol_c = (xTile_c - TILE_W'(BLOCK_START_X_TILE)) >> 3;
    blockRow_c = yTile_c - TILE_W'(BLOCK_START_Y_TILE);
    inGrid_c   = (blockCol_c < TILE_W'(BLOCK_COLS)) && (blockRow_c < TILE_W'(BLOCK_ROWS));
  end

  // Stage 2 block lookup, palette and priority
  always_comb begin
    blkIdx_c   = BIDX_W'(blockRowQ) * BIDX_W'(BLOCK_COLS) + BIDX_W'(blockColQ);
    present_c  = inGridQ && (|(blockSh & (NUM_BLOCKS'(1) << blkIdx_c)));
    flashHit_c = inGridQ && (flashCnt != 8'd0) && (BIDX_W'(flashIdx) == blkIdx_c);
    rowMod_c   = 3'(blockRowQ % TILE_W'(6));
    case (rowMod_c)
      3'd0:    palette_c = 8'h07;
      3'd1:    palette_c = 8'h1E;
      3'd2:    palette_c = 8'h3F;
      3'd3:    palette_c = 8'h30;
      3'd4:    palette_c = 8'hD0;
      3'd5:    palette_c = 8'h83;
      default: palette_c = 8'h00;
    endcase
    if (housingQ || paddleQ || ballQ) color_c = 8'hFF;
    else if (flashHit_c)              color_c = FLASH_COLOR;
    else if (present_c)               color_c = palette_c;
    else                              color_c = 8'h00;
    colorNext_c = color_c;
`ifdef SCANLINE_DIM_EN
    if (oddLineQ)
      colorNext_c = {1'b0, color_c[7:6], 1'b0, color_c[4:3], 1'b0, color_c[1]};
`endif
  end

  // Frame strobe, shadow snapshot and flash counter
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      FRAME_DONE  <= 1'b0;
      paddleXSh   <= '0;
      ballXSh     <= '0;
      ballYSh     <= '0;
      blockSh     <= '0;
      shadowValid <= 1'b0;
      flashIdx    <= '0;
      flashCnt    <= 8'd0;
    end else begin
      FRAME_DONE <= frameStrobe_c;
      if (frameStrobe_c) begin
        paddleXSh   <= PADDLE_X_PIXEL;
        ballXSh     <= BALL_X_PIXEL;
        ballYSh     <= BALL_Y_PIXEL;
        blockSh     <= BLOCK_STATE;
        shadowValid <= 1'b1;
        if (|cleared_c) begin
          flashIdx <= lowIdx_c;
          flashCnt <= 8'(FLASH_FRAMES);
        end else if (flashCnt != 8'd0) begin
          flashCnt <= flashCnt - 8'd1;
        end
      end
    end
  end

  // Pixel pipeline
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      housingQ  <= 1'b0;
      paddleQ   <= 1'b0;
      ballQ     <= 1'b0;
      inGridQ   <= 1'b0;
      blockRowQ <= '0;
      blockColQ <= '0;
`ifdef SCANLINE_DIM_EN
      oddLineQ  <= 1'b0;
`endif
      COLOR     <= 8'h00;
    end else begin
      housingQ  <= housing_c;
      paddleQ   <= paddle_c;
      ballQ     <= ball_c;
      inGridQ   <= inGrid_c;
      blockRowQ <= blockRow_c;
      blockColQ <= blockCol_c;
`ifdef SCANLINE_DIM_EN
      oddLineQ  <= Y_PIXEL[0];
`endif
      COLOR     <= colorNext_c;
    end
  end

endmodule

// File: tb/tb_game_renderer_multi.sv
// Directed, table-driven bench for game_renderer_multi (default parameters).
module tb_game_renderer_multi;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  X_PIXEL = 10'd24;
  logic [9:0]  Y_PIXEL = 10'd300;
  logic [9:0]  PADDLE_X_PIXEL = 10'd400;
  logic [19:0] BALL_X_PIXEL = {10'd300, 10'd100};
  logic [19:0] BALL_Y_PIXEL = {10'd300, 10'd200};
  logic [71:0] BLOCK_STATE = '0;
  logic [7:0]  COLOR;
  logic        FRAME_DONE;

  int checks = 0;
  int errors = 0;

  localparam logic [71:0] ALL_BLOCKS = {72{1'b1}};

  game_renderer_multi dut (
    .CLK(CLK), .RESET_N(RESET_N), .X_PIXEL(X_PIXEL), .Y_PIXEL(Y_PIXEL),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL),
    .BALL_Y_PIXEL(BALL_Y_PIXEL), .BLOCK_STATE(BLOCK_STATE),
    .COLOR(COLOR), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    int          bx0, by0, bx1, by1, px;
    logic [71:0] blocks;
    int          x, y;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] expAt(input logic [7:0] c, input int y);
`ifdef SCANLINE_DIM_EN
    if (y % 2 == 1) return {1'b0, c[7:6], 1'b0, c[4:3], 1'b0, c[1]};
`endif
    return c;
  endfunction

  task automatic addVec(input string name, input int bx0, input int by0, input int bx1,
                        input int by1, input int px, input logic [71:0] blocks,
                        input int x, input int y, input logic [7:0] exp);
    vec_t v;
    v.name = name; v.bx0 = bx0; v.by0 = by0; v.bx1 = bx1; v.by1 = by1; v.px = px;
    v.blocks = blocks; v.x = x; v.y = y; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Present a coordinate for one cycle; return COLOR two edges later
  task automatic render(input int x, input int y, output logic [7:0] c);
    X_PIXEL = 10'(x); Y_PIXEL = 10'(y);
    @(posedge CLK); #1;
    X_PIXEL = 10'd5; Y_PIXEL = 10'd5;
    @(posedge CLK); #1;
    c = COLOR;
  endtask

  task automatic renderCheck(input string name, input int x, input int y, input logic [7:0] exp);
    logic [7:0] c;
    render(x, y, c);
    check(name, c, expAt(exp, y));
  endtask

  // Frame boundary coordinate: strobe high one cycle after, low the next
  task automatic frame();
    X_PIXEL = 10'd0; Y_PIXEL = 10'd600;
    @(posedge CLK); #1;
    check("frame_done_high", 8'(FRAME_DONE), 8'd1);
    X_PIXEL = 10'd5; Y_PIXEL = 10'd5;
    @(posedge CLK); #1;
    check("frame_done_low", 8'(FRAME_DONE), 8'd0);
  endtask

  task automatic noStrobe(input string name, input int x, input int y);
    X_PIXEL = 10'(x); Y_PIXEL = 10'(y);
    @(posedge CLK); #1;
    check(name, 8'(FRAME_DONE), 8'd0);
  endtask

  task automatic setGame(input int bx0, input int by0, input int bx1, input int by1,
                         input int px, input logic [71:0] blocks);
    BALL_X_PIXEL   = {10'(bx1), 10'(bx0)};
    BALL_Y_PIXEL   = {10'(by1), 10'(by0)};
    PADDLE_X_PIXEL = 10'(px);
    BLOCK_STATE    = blocks;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0] b;

    // Balls, paddle, housing with no blocks
    addVec("ball0_tl",       100, 200, 300, 300, 400, '0, 100, 200, 8'hFF);
    addVec("ball0_x_edge",   100, 200, 300, 300, 400, '0, 108, 200, 8'h00);
    addVec("ball0_br",       100, 200, 300, 300, 400, '0, 107, 207, 8'hFF);
    addVec("ball0_y_edge",   100, 200, 300, 300, 400, '0, 100, 208, 8'h00);
    addVec("ball0_left",     100, 200, 300, 300, 400, '0,  99, 200, 8'h00);
    addVec("ball1",          100, 200, 300, 300, 400, '0, 300, 300, 8'hFF);
    addVec("ceiling_even",   100, 200, 300, 300, 400, '0, 200,  16, 8'hFF);
    addVec("ceiling_odd",    100, 200, 300, 300, 400, '0, 200,  17, 8'hFF);
    addVec("left_wall",      100, 200, 300, 300, 400, '0,  24, 300, 8'hFF);
    addVec("right_wall",     100, 200, 300, 300, 400, '0, 775, 400, 8'hFF);
    addVec("left_of_wall",   100, 200, 300, 300, 400, '0,  23, 300, 8'h00);
    addVec("wall_above",     100, 200, 300, 300, 400, '0,  24,   8, 8'h00);
    addVec("paddle_in",      100, 200, 300, 300, 400, '0, 400, 576, 8'hFF);
    addVec("paddle_end",     100, 200, 300, 300, 400, '0, 464, 576, 8'h00);
    // Block grid, all present
    addVec("blk_r0c0",       100, 200, 300, 300, 400, ALL_BLOCKS,  32,  48, 8'h07);
    addVec("blk_r1c1",       100, 200, 300, 300, 400, ALL_BLOCKS,  96,  56, 8'h1E);
    addVec("blk_r2",         100, 200, 300, 300, 400, ALL_BLOCKS,  32,  64, 8'h3F);
    addVec("blk_r3",         100, 200, 300, 300, 400, ALL_BLOCKS,  32,  72, 8'h30);
    addVec("blk_r4",         100, 200, 300, 300, 400, ALL_BLOCKS,  32,  80, 8'hD0);
    addVec("blk_r5",         100, 200, 300, 300, 400, ALL_BLOCKS,  32,  88, 8'h83);
    addVec("blk_r6_wrap",    100, 200, 300, 300, 400, ALL_BLOCKS,  32,  96, 8'h07);
    addVec("blk_r7",         100, 200, 300, 300, 400, ALL_BLOCKS,  32, 104, 8'h1E);
    addVec("blk_c8",         100, 200, 300, 300, 400, ALL_BLOCKS, 544,  48, 8'h07);
    addVec("blk_c9_out",     100, 200, 300, 300, 400, ALL_BLOCKS, 608,  48, 8'h00);
    addVec("blk_r8_out",     100, 200, 300, 300, 400, ALL_BLOCKS,  32, 112, 8'h00);
    addVec("blk_above_out",  100, 200, 300, 300, 400, ALL_BLOCKS,  32,  40, 8'h00);
    addVec("ball_over_blk",   32,  48, 300, 300, 400, ALL_BLOCKS,  32,  48, 8'hFF);
    addVec("paddle0_last",   100, 200, 300, 300,   0, ALL_BLOCKS,  63, 576, 8'hFF);
    addVec("paddle0_past",   100, 200, 300, 300,   0, ALL_BLOCKS,  64, 576, 8'h00);
    addVec("ball_nowrap",   1020, 590, 300, 300,   0, ALL_BLOCKS,   2, 592, 8'h00);
    addVec("ball_far_x",    1020, 590, 300, 300,   0, ALL_BLOCKS, 1023, 591, 8'hFF);
    addVec("ball_far_y",    1020, 590, 300, 300,   0, ALL_BLOCKS, 1023, 597, 8'hFF);
    addVec("ball_far_yend", 1020, 590, 300, 300,   0, ALL_BLOCKS, 1023, 598, 8'h00);

    // Three reset cycles mid-line, including the frame coordinate
    @(posedge CLK); #1;
    check("rst_color_1", COLOR, 8'h00);
    check("rst_fd_1", 8'(FRAME_DONE), 8'd0);
    X_PIXEL = 10'd0; Y_PIXEL = 10'd600;
    @(posedge CLK); #1;
    check("rst_color_2", COLOR, 8'h00);
    check("rst_fd_2", 8'(FRAME_DONE), 8'd0);
    X_PIXEL = 10'd24; Y_PIXEL = 10'd300;
    @(posedge CLK); #1;
    check("rst_color_3", COLOR, 8'h00);
    check("rst_fd_3", 8'(FRAME_DONE), 8'd0);
    RESET_N = 1'b1;

    // Before the first snapshot only housing is drawn
    renderCheck("pre_snap_housing", 24, 300, 8'hFF);
    renderCheck("pre_snap_origin", 3, 3, 8'h00);
    renderCheck("pre_snap_paddle", 10, 576, 8'h00);
    renderCheck("pre_snap_ball", 100, 200, 8'h00);
    noStrobe("no_strobe_x1", 1, 600);
    noStrobe("no_strobe_y599", 0, 599);

    foreach (vecs[i]) begin
      setGame(vecs[i].bx0, vecs[i].by0, vecs[i].bx1, vecs[i].by1, vecs[i].px, vecs[i].blocks);
      frame();
      renderCheck(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].exp);
    end

    // Mid-frame input changes stay invisible until the snapshot
    b = ALL_BLOCKS;
    b[1] = 1'b0;
    BLOCK_STATE = b;
    BALL_X_PIXEL[9:0] = 10'd500;
    renderCheck("midframe_block", 96, 48, 8'h07);
    renderCheck("midframe_ball", 1023, 591, 8'hFF);
    frame();
    renderCheck("flash_blk1", 96, 48, 8'hFC);
    renderCheck("ball_moved", 1023, 591, 8'h00);

    // Clearing blocks 3 and 5 together overrides the block-1 flash
    b[3] = 1'b0;
    b[5] = 1'b0;
    BLOCK_STATE = b;
    frame();
    renderCheck("flash_b3_f1", 224, 48, 8'hFC);
    renderCheck("blk5_black", 352, 48, 8'h00);
    renderCheck("blk1_override", 96, 48, 8'h00);
    renderCheck("blk4_normal", 288, 48, 8'h07);
    for (int f = 2; f <= 8; f++) begin
      frame();
      renderCheck($sformatf("flash_b3_f%0d", f), 224, 48, 8'hFC);
    end
    frame();
    renderCheck("flash_b3_end", 224, 48, 8'h00);
    frame();
    renderCheck("flash_b3_stays", 224, 48, 8'h00);
    renderCheck("blk5_still_black", 352, 48, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_renderer_multi.md
Name: game_renderer_multi

Overview:
- Parametrised successor of the single-ball game renderer.
- Maps the current pixel coordinate (from the external SVGA timing generator) to an 8-bit RRRGGGBB colour through a 2-stage pipeline.
- Supports N balls and a configurable block grid; snapshots the game state at each frame boundary, so frames render tear-free.
- Flashes the most recently destroyed block for a configurable number of frames. Sits between the game logic and the video output.

Parameters:
- BLOCK_COLS, 9, block grid columns; each block is 8 tiles (64 px) wide.
- BLOCK_ROWS, 8, block grid rows; each row is 1 tile (8 px) high.
- BALL_COUNT, 2, number of balls rendered (1..4).
- BALL_SIZE_PX, 8, ball edge length in pixels.
- PADDLE_LEN_PX, 64, paddle length in pixels.
- CEILING_Y_TILE, 2; LEFT_WALL_X_TILE, 3; RIGHT_WALL_X_TILE, 96; PADDLE_Y_TILE, 72: housing and paddle geometry, in 8 px tiles.
- BLOCK_START_X_TILE, 4; BLOCK_START_Y_TILE, 6: top-left of the block grid, in tiles.
- FRAME_LINE, 600, Y_PIXEL value at which FRAME_DONE fires (with X_PIXEL==0).
- FLASH_FRAMES, 8, frames a destroyed block stays flashing (1..255).
- FLASH_COLOR, 8'hFC, colour of the flashing block.

Ports:
- CLK  in  1  pixel clock
- RESET_N  in  1  synchronous active-low reset
- X_PIXEL  in  10  current pixel column from the timing generator
- Y_PIXEL  in  10  current pixel row from the timing generator
- PADDLE_X_PIXEL  in  10  paddle left edge
- BALL_X_PIXEL  in  10*BALL_COUNT  ball i occupies bits [10i+9:10i]
- BALL_Y_PIXEL  in  10*BALL_COUNT  same packing as BALL_X_PIXEL
- BLOCK_STATE  in  BLOCK_ROWS*BLOCK_COLS  bit r*BLOCK_COLS+c set = block present
- COLOR  out  8  pixel colour, 2 cycles after its coordinate
- FRAME_DONE  out  1  one-cycle frame strobe for the game logic

Behaviour:
- Reset:
  - Applies on the CLK edge while RESET_N==0; one clock, synchronous, active-low.
  - Clears COLOR=0, FRAME_DONE=0, pipeline registers, all shadow state (paddle, balls, blocks = 0) and flash counter = 0.
  - Reset mid-frame: output is black except housing until the first snapshot.
- Frame strobe:
  - FRAME_DONE registers (X_PIXEL==0 && Y_PIXEL==FRAME_LINE); asserted exactly 1 cycle after that coordinate, for 1 cycle.
- Snapshot:
  - On the same cycle the strobe condition is true, the shadow registers load PADDLE_X_PIXEL, BALL_*, BLOCK_STATE.
  - All rendering uses shadow values only; input changes mid-frame are invisible until the next snapshot.
- Flash:
  - At snapshot, cleared = shadow_blocks & ~BLOCK_STATE.
  - If cleared!=0: flash_idx := lowest set index, flash_cnt := FLASH_FRAMES. A new clear overrides a running flash.
  - Else, if flash_cnt!=0: flash_cnt decrements by 1.
  - The block flash_idx is drawn in FLASH_COLOR while flash_cnt!=0, even though its bit is clear.
- Pipeline:
  - Stage 1 registers the tile coordinates, the housing/paddle/ball hit flags, block row/col and grid-in-range.
  - Stage 2 registers COLOR.
  - Total latency 2 cycles, fixed, no stalls; the timing generator delays its syncs by 2.
- Hit tests:
  - Paddle: Ytile==PADDLE_Y_TILE and PX<=X<PX+PADDLE_LEN_PX.
  - Ball i: BX<=X<BX+BALL_SIZE_PX and BY<=Y<BY+BALL_SIZE_PX.
  - Compute all sums at 11 bits so positions near 1023 do not wrap.
- Block grid: col = (Xtile-BLOCK_START_X_TILE)>>3, row = Ytile-BLOCK_START_Y_TILE, computed 7-bit unsigned; coordinates left of or above the grid underflow to large values and fall outside.
- Row palette, indexed by row mod 6: 07, 1E, 3F, 30, D0, 83 (hex).
- Colour priority: housing | paddle | any ball -> FF; else flash block -> FLASH_COLOR; else present block -> row palette; else 00.

Optional Feature:
- SCANLINE_DIM_EN defined: on odd Y_PIXEL, stage 2 outputs each channel shifted right by 1 ({0,R[2:1]}, {0,G[2:1]}, {0,B[1]}); FF becomes 0x6D.
- SCANLINE_DIM_EN undefined: no dimming; odd and even lines are identical.

Test Plan:
- Reset with RESET_N=0 for 3 cycles mid-line -> COLOR=00 and FRAME_DONE=0 throughout; first strobe comes 1 cycle after (0,600).
- Ball0 at (100,200), drive coordinate (100,200) -> COLOR=FF 2 cycles later; (108,200) -> 00; ball1 at (300,300) likewise FF.
- All blocks set, coordinate (32,48) (tile 4,6) -> COLOR=07; (96,56) -> 1E; BLOCK_STATE changed mid-frame -> colour unchanged until after the snapshot.
- Clear bits 3 and 5 at one snapshot -> block 3 shows FC for exactly 8 frames; block 5 stays black; then block 3 is black.
- Ball at (1020,590), coordinate (2,592) -> COLOR=00 (no wrap); paddle at 0, coordinate (63,576) -> FF, (64,576) -> 00.
- With SCANLINE_DIM_EN defined, housing pixel on line 17 -> 6D, on line 16 -> FF.
